// File: rtl/breakout_pkg.sv
// -----------------------------------------------------------------------------
// breakout_pkg
// Shared types and constants for the Breakout game sequencer.
//   game_state_t     : encoded game state, also presented on the HUD port
//   TOTAL_BRICKS     : brick count right after a brick-array clear
//   LIVES_W, LEVEL_W : widths of the lives and level counters
//   BRICKS_W         : width of the brick-array live count
//   EXTRA_LIFE_STEP  : score band size for the optional extra-life award
// -----------------------------------------------------------------------------
package breakout_pkg;

  typedef enum logic [2:0] {
    GS_IDLE     = 3'd0,
    GS_CLEAR    = 3'd1,
    GS_SERVE    = 3'd2,
    GS_PLAY     = 3'd3,
    GS_WON      = 3'd4,
    GS_GAMEOVER = 3'd5
  } game_state_t;

  localparam int TOTAL_BRICKS    = 28;
  localparam int LIVES_W         = 2;
  localparam int LEVEL_W         = 3;
  localparam int BRICKS_W        = 5;
  localparam int EXTRA_LIFE_STEP = 500;

endpackage

// File: rtl/frame_timer.sv
// -----------------------------------------------------------------------------
// frame_timer
// Loadable down-counter of frame_tick pulses, shared by the serve wait and
// the level-cleared pause.
//   clk, reset  : clock, synchronous active-high reset
//   load        : load load_val this cycle (wins over a coincident tick)
//   load_val    : number of ticks to wait
//   frame_tick  : one-cycle pulse per video frame
//   done        : combinational, high on the tick that ends the wait
// -----------------------------------------------------------------------------
module frame_timer #(
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             frame_tick,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every signal written in always_comb gets a default first so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (frame_tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // done deliberately ignores load: the owner only consults it while
  // waiting, and the counter has always run down to 0 before the next load,
  // so keeping load out avoids a combinational loop through the FSM.
  assign done = frame_tick && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/breakout_game_ctrl.sv
// -----------------------------------------------------------------------------
// breakout_game_ctrl
// Game sequencer: IDLE -> CLEAR -> SERVE -> PLAY -> WON/GAMEOVER, with
// lives, level and score bookkeeping. All outputs are registered.
//   clk, reset        : clock, synchronous active-high reset
//   frame_tick        : one-cycle pulse per video frame
//   start_btn         : debounced start button (level)
//   ball_missed       : one-cycle pulse, ball fell below the paddle
//   bricks_remaining  : live brick count from the brick array
//   brick_clear       : one-cycle brick-array clear pulse
//   ball_serve        : one-cycle centre-and-launch pulse
//   ball_enable       : ball motion and collisions allowed
//   lives, level, score, game_state : HUD information
// Optional feature macro: BREAKOUT_EXTRA_LIFE_EN (extra life every time the
// score carries into the next EXTRA_LIFE_STEP band, lives saturate at 3).
// -----------------------------------------------------------------------------
module breakout_game_ctrl #(
  parameter int TOTAL_BRICKS = breakout_pkg::TOTAL_BRICKS,
  parameter int LIVES_INIT   = 3,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_FRAMES   = 120,
  parameter int SCORE_W      = 12,
  parameter int LEVEL_MAX    = 7
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              frame_tick,
  input  logic                              start_btn,
  input  logic                              ball_missed,
  input  logic [breakout_pkg::BRICKS_W-1:0] bricks_remaining,
  output logic                              brick_clear,
  output logic                              ball_serve,
  output logic                              ball_enable,
  output logic [breakout_pkg::LIVES_W-1:0]  lives,
  output logic [breakout_pkg::LEVEL_W-1:0]  level,
  output logic [SCORE_W-1:0]                score,
  output logic [2:0]                        game_state
);

  import breakout_pkg::*;

  localparam logic [2:0] S_IDLE     = GS_IDLE;
  localparam logic [2:0] S_CLEAR    = GS_CLEAR;
  localparam logic [2:0] S_SERVE    = GS_SERVE;
  localparam logic [2:0] S_PLAY     = GS_PLAY;
  localparam logic [2:0] S_WON      = GS_WON;
  localparam logic [2:0] S_GAMEOVER = GS_GAMEOVER;

  localparam int TMR_MAX = (SERVE_FRAMES > WIN_FRAMES) ? SERVE_FRAMES : WIN_FRAMES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [LIVES_W-1:0] LIVES_MAX = '1;

  logic [2:0]          state_q, state_d;
  logic [LIVES_W-1:0]  lives_q, lives_d;
  logic [LEVEL_W-1:0]  level_q, level_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [BRICKS_W-1:0] prev_bricks_q, prev_bricks_d;
  logic                start_q;
  logic                brick_clear_q, brick_clear_d;
  logic                ball_serve_q, ball_serve_d;
  logic                ball_enable_q, ball_enable_d;

  logic                start_rise;
  logic                hit;
  logic [8:0]          hit_pts;
  logic [SCORE_W:0]    score_sum;
  logic [SCORE_W-1:0]  score_sat;
  logic                lose_life;
  logic                award_life;
  logic [LIVES_W:0]    lives_net;
  logic                tmr_load;
  logic [TMR_W-1:0]    tmr_val;
  logic                tmr_done;

  assign start_rise = start_btn && !start_q;

  // Points for this cycle's hit; only meaningful when hit is set, so the
  // subtraction never underflows where it is used.
  assign hit       = (bricks_remaining < prev_bricks_q);
  assign hit_pts   = 9'(prev_bricks_q - bricks_remaining) * (9'(level_q) + 9'd1);
  assign score_sum = {1'b0, score_q} + (SCORE_W+1)'(hit_pts);
  assign score_sat = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

  frame_timer #(.CNT_W(TMR_W)) u_frame_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (tmr_load),
    .load_val   (tmr_val),
    .frame_tick (frame_tick),
    .done       (tmr_done)
  );

  always_comb begin
    state_d       = state_q;
    lives_d       = lives_q;
    level_d       = level_q;
    score_d       = score_q;
    prev_bricks_d = prev_bricks_q;
    brick_clear_d = 1'b0;
    ball_serve_d  = 1'b0;
    tmr_load      = 1'b0;
    tmr_val       = TMR_W'(SERVE_FRAMES);
    lose_life     = 1'b0;
    award_life    = 1'b0;
    lives_net     = {1'b0, lives_q};

    case (state_q)
      S_IDLE: begin
        if (start_rise) begin
          lives_d       = LIVES_W'(LIVES_INIT);
          level_d       = '0;
          score_d       = '0;
          brick_clear_d = 1'b1;
          state_d       = S_CLEAR;
        end
      end
      S_CLEAR: begin
        // Loading the timer on the transition means a tick coincident with
        // entering SERVE is swallowed by the load.
        prev_bricks_d = BRICKS_W'(TOTAL_BRICKS);
        tmr_load      = 1'b1;
        state_d       = S_SERVE;
      end
      S_SERVE: begin
        if (tmr_done) begin
          ball_serve_d = 1'b1;
          state_d      = S_PLAY;
        end
      end
      S_PLAY: begin
        prev_bricks_d = bricks_remaining;
        if (hit) begin
          score_d = score_sat;
        end
        // A win outranks a simultaneous miss: no life is lost.
        if (bricks_remaining == '0) begin
          level_d  = (level_q == LEVEL_W'(LEVEL_MAX)) ? level_q : level_q + 1'b1;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(WIN_FRAMES);
          state_d  = S_WON;
        end else if (ball_missed) begin
          lose_life = 1'b1;
        end
      end
      S_WON: begin
        if (tmr_done) begin
          brick_clear_d = 1'b1;
          state_d       = S_CLEAR;
        end
      end
      S_GAMEOVER: begin
        if (start_rise) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef BREAKOUT_EXTRA_LIFE_EN
    // Carry into the next score band; a saturated score cannot carry again.
    award_life = (state_q == S_PLAY) && hit &&
                 ((32'(score_d) / EXTRA_LIFE_STEP) != (32'(score_q) / EXTRA_LIFE_STEP));
`endif

    // Net lives change; an award and a loss in the same cycle cancel out.
    lives_net = {1'b0, lives_q} + {{LIVES_W{1'b0}}, award_life}
                - {{LIVES_W{1'b0}}, lose_life};
    if (award_life || lose_life) begin
      lives_d = (lives_net > {1'b0, LIVES_MAX}) ? LIVES_MAX : lives_net[LIVES_W-1:0];
    end
    if (lose_life) begin
      if (lives_net == '0) begin
        state_d = S_GAMEOVER;
      end else begin
        tmr_load = 1'b1;
        state_d  = S_SERVE;
      end
    end

    ball_enable_d = (state_d == S_PLAY);
  end

  // Registered outputs line up with the state that the decision selects.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      lives_q       <= LIVES_W'(LIVES_INIT);
      level_q       <= '0;
      score_q       <= '0;
      prev_bricks_q <= BRICKS_W'(TOTAL_BRICKS);
      start_q       <= 1'b0;
      brick_clear_q <= 1'b0;
      ball_serve_q  <= 1'b0;
      ball_enable_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      lives_q       <= lives_d;
      level_q       <= level_d;
      score_q       <= score_d;
      prev_bricks_q <= prev_bricks_d;
      start_q       <= start_btn;
      brick_clear_q <= brick_clear_d;
      ball_serve_q  <= ball_serve_d;
      ball_enable_q <= ball_enable_d;
    end
  end

  assign brick_clear = brick_clear_q;
  assign ball_serve  = ball_serve_q;
  assign ball_enable = ball_enable_q;
  assign lives       = lives_q;
  assign level       = level_q;
  assign score       = score_q;
  assign game_state  = state_q;

endmodule
